// File: rtl/axil_arb_pkg.sv
// Shared types and AXI constants for the AXI4-Lite request arbiter.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WRESP,
        ST_RD,
        ST_RDATA,
        ST_RESP
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_SLVERR      = 2'b10;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   grant_idx_c,
    output logic               any_c
);

    // First pass covers indices above last_grant, second pass wraps to the rest.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!any_c && req[j] && (IDX_W'(j) > last_grant)) begin
                any_c       = 1'b1;
                grant_c[j]  = 1'b1;
                grant_idx_c = IDX_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!any_c && req[j] && (IDX_W'(j) <= last_grant)) begin
                any_c       = 1'b1;
                grant_c[j]  = 1'b1;
                grant_idx_c = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/axil_req_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port among NUM_REQ single-beat requesters.
// Optional per-phase timeout enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_req_arbiter
    import axil_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          timeout_err,
    output logic [ADDR_W-1:0]             m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_W-1:0]             m_axi_wdata,
    output logic [DATA_W/8-1:0]           m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [ADDR_W-1:0]             m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_W-1:0]             m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_t          state;
    logic [IDX_W-1:0]    last_grant;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    logic [NUM_REQ-1:0]  arb_grant_c;
    logic [IDX_W-1:0]    arb_idx_c;
    logic                arb_any_c;
    logic                sel_we_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;
    logic [STRB_W-1:0]   sel_wstrb_c;
    logic                in_phase_c;
    logic                phase_adv_c;
    logic                timeout_hit_c;
    logic                timeout_en;
    logic [CNT_W-1:0]    phase_cnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c),
        .any_c       (arb_any_c)
    );

    // Mux the winning requester's fields.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        sel_wstrb_c = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (arb_grant_c[j]) begin
                sel_we_c    = req_we[j];
                sel_addr_c  = req_addr[j*ADDR_W +: ADDR_W];
                sel_wdata_c = req_wdata[j*DATA_W +: DATA_W];
                sel_wstrb_c = req_wstrb[j*STRB_W +: STRB_W];
            end
        end
    end

    // Phase completion: the handshake that moves the FSM out of a bus-waiting state.
    always_comb begin
        in_phase_c  = 1'b0;
        phase_adv_c = 1'b0;
        case (state)
            ST_WR: begin
                in_phase_c  = 1'b1;
                phase_adv_c = (!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready);
            end
            ST_WRESP: begin
                in_phase_c  = 1'b1;
                phase_adv_c = m_axi_bvalid;
            end
            ST_RD: begin
                in_phase_c  = 1'b1;
                phase_adv_c = m_axi_arready;
            end
            ST_RDATA: begin
                in_phase_c  = 1'b1;
                phase_adv_c = m_axi_rvalid;
            end
            default: begin
                in_phase_c  = 1'b0;
                phase_adv_c = 1'b0;
            end
        endcase
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    assign timeout_en = 1'b1;

    always_ff @(posedge ACLK) begin
        if (ARESET || !in_phase_c || phase_adv_c) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end
`else
    assign timeout_en = 1'b0;
    assign phase_cnt  = '0;
`endif

    // A completing handshake always wins over a same-cycle timeout.
    assign timeout_hit_c = timeout_en && in_phase_c && !phase_adv_c &&
                           (phase_cnt == CNT_W'(TIMEOUT_CYC - 1));

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_awprot = AXI_PROT_DEFAULT;
    assign m_axi_arprot = AXI_PROT_DEFAULT;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= ST_IDLE;
            last_grant    <= IDX_W'(NUM_REQ - 1);
            grant_oh      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            busy          <= 1'b0;
            grant_id      <= '0;
            timeout_err   <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any_c) begin
                        req_ready <= arb_grant_c;
                        grant_oh  <= arb_grant_c;
                        grant_id  <= arb_idx_c;
                        addr_q    <= sel_addr_c;
                        wdata_q   <= sel_wdata_c;
                        wstrb_q   <= sel_wstrb_c;
                        busy      <= 1'b1;
                        if (sel_we_c) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= ST_WR;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    if (phase_adv_c) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        m_axi_bready  <= 1'b1;
                        state         <= ST_WRESP;
                    end else begin
                        if (m_axi_awready) m_axi_awvalid <= 1'b0;
                        if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    end
                end
                ST_WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        rsp_valid    <= grant_oh;
                        state        <= ST_RESP;
                    end
                end
                ST_RD: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_valid    <= grant_oh;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
            // Timeout abandons the bus phase and reports SLVERR to the requester.
            if (timeout_hit_c) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                rsp_resp      <= RESP_SLVERR;
                rsp_rdata     <= '0;
                rsp_valid     <= grant_oh;
                timeout_err   <= 1'b1;
                state         <= ST_RESP;
            end
        end
    end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Scoreboard bench for axil_req_arbiter with a small AXI4-Lite slave/memory model.
module tb_axil_req_arbiter;
    import axil_arb_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned IDX_W   = 2;

    logic tb_ACLK = 1'b0;
    logic ARESET  = 1'b1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*STRB_W-1:0] req_wstrb;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [1:0]                rsp_resp;
    logic                      busy;
    logic [IDX_W-1:0]          grant_id;
    logic                      timeout_err;
    logic [ADDR_W-1:0]         m_axi_awaddr;
    logic [2:0]                m_axi_awprot;
    logic                      m_axi_awvalid;
    logic                      m_axi_awready;
    logic [DATA_W-1:0]         m_axi_wdata;
    logic [STRB_W-1:0]         m_axi_wstrb;
    logic                      m_axi_wvalid;
    logic                      m_axi_wready;
    logic [1:0]                m_axi_bresp;
    logic                      m_axi_bvalid;
    logic                      m_axi_bready;
    logic [ADDR_W-1:0]         m_axi_araddr;
    logic [2:0]                m_axi_arprot;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [DATA_W-1:0]         m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;

    always #5 tb_ACLK = ~tb_ACLK;

    axil_req_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESET        (ARESET),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .busy          (busy),
        .grant_id      (grant_id),
        .timeout_err   (timeout_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // ---------------- slave model ----------------
    int          aw_delay  = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        ar_block  = 1'b0;
    logic        r_block   = 1'b0;
    int          aw_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_s, w_data_s;
    logic [3:0]  w_strb_s;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] s_tmp;

    assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
    assign m_axi_wready  = m_axi_wvalid;
    assign m_axi_arready = m_axi_arvalid && !ar_block;

    wire        aw_fire = m_axi_awvalid && m_axi_awready;
    wire        w_fire  = m_axi_wvalid && m_axi_wready;
    wire [31:0] wr_addr = aw_fire ? m_axi_awaddr : aw_addr_s;
    wire [31:0] wr_data = w_fire ? m_axi_wdata : w_data_s;
    wire [3:0]  wr_strb = w_fire ? m_axi_wstrb : w_strb_s;

    always @(posedge tb_ACLK) begin
        if (ARESET) begin
            aw_wait      <= 0;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            m_axi_bvalid <= 1'b0;
            m_axi_bresp  <= 2'b00;
            m_axi_rvalid <= 1'b0;
            m_axi_rdata  <= '0;
            m_axi_rresp  <= 2'b00;
        end else begin
            aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if ((aw_got || aw_fire) && (w_got || w_fire)) begin
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= bresp_cfg;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
                if (bresp_cfg == RESP_OKAY) begin
                    s_tmp = smem.exists(wr_addr) ? smem[wr_addr] : 32'h0;
                    for (int b = 0; b < 4; b++) if (wr_strb[b]) s_tmp[8*b +: 8] = wr_data[8*b +: 8];
                    smem[wr_addr] = s_tmp;
                end
            end else begin
                if (aw_fire) begin aw_got <= 1'b1; aw_addr_s <= m_axi_awaddr; end
                if (w_fire)  begin w_got <= 1'b1; w_data_s <= m_axi_wdata; w_strb_s <= m_axi_wstrb; end
            end
            if (m_axi_arvalid && m_axi_arready && !r_block) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= smem.exists(m_axi_araddr) ? smem[m_axi_araddr] : 32'h0;
                m_axi_rresp  <= RESP_OKAY;
            end else if (m_axi_rvalid && m_axi_rready) begin
                m_axi_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [NUM_REQ-1:0] oh;
        logic [DATA_W-1:0]  rdata;
        logic [1:0]         resp;
    } rsp_exp_t;

    logic [NUM_REQ-1:0] exp_rdy_q [$];
    rsp_exp_t           exp_rsp_q [$];
    logic [31:0]        ref_mem [logic [31:0]];
    rsp_exp_t           mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_grants = 0;
    int rsp_cyc = 0, aw_hs_cyc = 0;
    int aw_hi = 0, w_hi = 0, b_hs = 0, aw_unstable = 0;
    logic aw_prev = 1'b0;
    logic [31:0] aw_first;
    logic hold_all = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge tb_ACLK) cyc <= cyc + 1;

    always @(negedge tb_ACLK) begin
        if (!ARESET) begin
            if (req_ready != '0) begin
                n_grants++;
                if (exp_rdy_q.size() == 0) check_eq("req_ready_unexpected", 64'(req_ready), 64'd0);
                else check_eq("req_ready", 64'(req_ready), 64'(exp_rdy_q.pop_front()));
            end
            if (rsp_valid != '0) begin
                rsp_cyc = cyc;
                if (exp_rsp_q.size() == 0) begin
                    check_eq("rsp_valid_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    mon_e = exp_rsp_q.pop_front();
                    check_eq("rsp_valid", 64'(rsp_valid), 64'(mon_e.oh));
                    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                    check_eq("rsp_resp", 64'(rsp_resp), 64'(mon_e.resp));
                end
            end
            if (m_axi_awvalid) begin
                if (!aw_prev) aw_first = m_axi_awaddr;
                else if (m_axi_awaddr != aw_first) aw_unstable++;
                aw_hi++;
                if (m_axi_awready) aw_hs_cyc = cyc;
            end
            aw_prev = m_axi_awvalid;
            if (m_axi_wvalid) w_hi++;
            if (m_axi_bvalid && m_axi_bready) b_hs++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge tb_ACLK);
        #1;
        if (!hold_all) req_valid = req_valid & ~req_ready;
    endtask

    task automatic issue(input int r, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        rsp_exp_t e;
        logic [31:0] m;
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        req_we[r] = we;
        req_addr[r*ADDR_W +: ADDR_W]  = a;
        req_wdata[r*DATA_W +: DATA_W] = d;
        req_wstrb[r*STRB_W +: STRB_W] = s;
        req_valid[r] = 1'b1;
        e.oh = oh;
        if (we) begin
            e.rdata = '0;
            e.resp  = bresp_cfg;
            if (bresp_cfg == RESP_OKAY) begin
                m = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
                for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
                ref_mem[a] = m;
            end
        end else if (ar_block) begin
            e.rdata = '0;
            e.resp  = RESP_SLVERR;
        end else begin
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            e.resp  = RESP_OKAY;
        end
        exp_rdy_q.push_back(oh);
        exp_rsp_q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (exp_rsp_q.size() == 0 && !busy && req_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({"done_", tag}, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, g0, aw0, w0, b0, u0;
        bit ok;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;

        repeat (3) step();
        check_eq("reset_outputs",
                 64'({busy, req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                      m_axi_arvalid, m_axi_rready, timeout_err, grant_id}), 64'd0);
        ARESET = 1'b0;
        step();

        // Zero-wait write from requester 0.
        t0 = cyc;
        issue(0, 1'b1, 32'hFFFC_0000, 32'hDEAD_BEEF, 4'hF);
        wait_done("wr0", 20);
        check_eq("wr0_aw_latency", 64'(aw_hs_cyc - t0), 64'd1);
        check_eq("wr0_rsp_latency", 64'(rsp_cyc - t0), 64'd3);

        // Read back through requester 1.
        t0 = cyc;
        issue(1, 1'b0, 32'hFFFC_0000, 32'h0, 4'h0);
        wait_done("rd1", 20);
        check_eq("rd1_rsp_latency", 64'(rsp_cyc - t0), 64'd3);

        // Fresh reset, then all four requesters held: order 0,1,2,3,0.
        ARESET = 1'b1;
        repeat (2) step();
        ARESET = 1'b0;
        step();
        hold_all = 1'b1;
        g0 = n_grants;
        for (int r = 0; r < 4; r++) issue(r, 1'b1, 32'hFFFC_0100 + 32'(4 * r), 32'h1000 + 32'(r), 4'hF);
        issue(0, 1'b1, 32'hFFFC_0100, 32'h1000, 4'hF);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (n_grants - g0 >= 5) begin ok = 1'b1; break; end
        end
        check_eq("rr_five_grants", 64'(ok), 64'd1);
        req_valid = '0;
        hold_all  = 1'b0;
        wait_done("rr", 30);

        // Delayed awready, immediate wready.
        aw_delay = 5;
        aw0 = aw_hi; w0 = w_hi; b0 = b_hs; u0 = aw_unstable;
        step();
        issue(2, 1'b1, 32'hFFFC_0200, 32'hCAFE_F00D, 4'hF);
        wait_done("aw_delay", 30);
        check_eq("awvalid_cycles", 64'(aw_hi - aw0), 64'd6);
        check_eq("wvalid_cycles", 64'(w_hi - w0), 64'd1);
        check_eq("b_handshakes", 64'(b_hs - b0), 64'd1);
        check_eq("awaddr_stable", 64'(aw_unstable - u0), 64'd0);
        aw_delay = 0;

        // SLVERR on B forwarded to requester 3.
        bresp_cfg = RESP_SLVERR;
        step();
        issue(3, 1'b1, 32'hFFFC_0300, 32'h5555_AAAA, 4'h3);
        wait_done("bresp_err", 20);
        bresp_cfg = RESP_OKAY;

        // Reset while waiting in RDATA.
        r_block = 1'b1;
        step();
        issue(2, 1'b0, 32'hFFFC_0000, 32'h0, 4'h0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_axi_rready) begin ok = 1'b1; break; end
        end
        check_eq("reached_rdata", 64'(ok), 64'd1);
        ARESET = 1'b1;
        step();
        check_eq("rst_mid_rready", 64'(m_axi_rready), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        ARESET = 1'b0;
        exp_rsp_q.delete();
        exp_rdy_q.delete();
        r_block = 1'b0;
        step();

        // Slave never accepts AR.
        ar_block = 1'b1;
        t0 = cyc;
        issue(1, 1'b0, 32'hFFFC_0000, 32'h0, 4'h0);
`ifdef AXIL_ARB_TIMEOUT_EN
        wait_done("timeout", 60);
        check_eq("timeout_latency", 64'(rsp_cyc - t0), 64'd17);
        check_eq("timeout_err_set", 64'(timeout_err), 64'd1);
`else
        repeat (40) step();
        check_eq("stall_busy", 64'(busy), 64'd1);
        check_eq("stall_arvalid", 64'(m_axi_arvalid), 64'd1);
        check_eq("stall_timeout_err", 64'(timeout_err), 64'd0);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        exp_rsp_q.delete();
        exp_rdy_q.delete();
`endif
        ar_block = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
